// File: rtl/load_store_unit.sv
// Memory stage of the RV32I pipeline: store alignment/strobes, load extraction,
// req/gnt + rvalid handshake with data memory, and a valid/ready output register.
module load_store_unit #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [AWIDTH-1:0]     in_pc_i,
    input  logic [DWIDTH-1:0]     in_alu_res_i,
    input  logic [DWIDTH-1:0]     in_store_data_i,
    input  logic [2:0]            in_funct3_i,
    input  logic                  in_memren_i,
    input  logic                  in_memwren_i,
    input  logic [4:0]            in_rd_i,
    input  logic                  in_regwren_i,
    input  logic [1:0]            in_wbsel_i,

    output logic                  dmem_req_o,
    input  logic                  dmem_gnt_i,
    output logic [AWIDTH-1:0]     dmem_addr_o,
    output logic                  dmem_we_o,
    output logic [DWIDTH/8-1:0]   dmem_wstrb_o,
    output logic [DWIDTH-1:0]     dmem_wdata_o,
    input  logic                  dmem_rvalid_i,
    input  logic [DWIDTH-1:0]     dmem_rdata_i,

    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [AWIDTH-1:0]     out_pc_o,
    output logic [DWIDTH-1:0]     out_alu_res_o,
    output logic [DWIDTH-1:0]     out_load_data_o,
    output logic [4:0]            out_rd_o,
    output logic [1:0]            out_wbsel_o,
    output logic                  out_regwren_o,
    output logic                  out_exc_o
);

    localparam int SWIDTH = DWIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t             state;
    logic [1:0]         off_q;
    logic [2:0]         funct3_q;
    logic               is_load_q;

    logic               accept;
    logic               mem_op;
    logic               illegal;
    logic               misaligned;
    logic               exc;
    logic [1:0]         off;
    logic [DWIDTH-1:0]  store_masked;
    logic [DWIDTH-1:0]  store_shifted;
    logic [SWIDTH-1:0]  strb_base;
    logic [SWIDTH-1:0]  strb_shifted;
    logic [DWIDTH-1:0]  load_word;
    logic [DWIDTH-1:0]  load_ext;

    assign in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        off        = in_alu_res_i[1:0];
        mem_op     = in_memren_i | in_memwren_i;
        illegal    = (in_memren_i & in_memwren_i) |
                     (mem_op & ((in_funct3_i == 3'b011) | (in_funct3_i == 3'b110) |
                                (in_funct3_i == 3'b111)));
        misaligned = 1'b0;
        case (in_funct3_i[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        exc = mem_op & (illegal | misaligned);

        store_masked = in_store_data_i;
        strb_base    = '1;
        case (in_funct3_i[1:0])
            2'b00: begin
                store_masked = {{(DWIDTH-8){1'b0}}, in_store_data_i[7:0]};
                strb_base    = SWIDTH'(1);
            end
            2'b01: begin
                store_masked = {{(DWIDTH-16){1'b0}}, in_store_data_i[15:0]};
                strb_base    = SWIDTH'(3);
            end
            default: begin
                store_masked = in_store_data_i;
                strb_base    = '1;
            end
        endcase
        store_shifted = store_masked << {off, 3'b000};
        strb_shifted  = strb_base << off;
    end

    // Extraction uses the offset/size captured at accept, not the live inputs.
    always_comb begin
        load_word = dmem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(DWIDTH-8){load_word[7]}}, load_word[7:0]};
            3'b100:  load_ext = {{(DWIDTH-8){1'b0}}, load_word[7:0]};
            3'b001:  load_ext = {{(DWIDTH-16){load_word[15]}}, load_word[15:0]};
            3'b101:  load_ext = {{(DWIDTH-16){1'b0}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            off_q           <= '0;
            funct3_q        <= '0;
            is_load_q       <= 1'b0;
            dmem_req_o      <= 1'b0;
            dmem_addr_o     <= '0;
            dmem_we_o       <= 1'b0;
            dmem_wstrb_o    <= '0;
            dmem_wdata_o    <= '0;
            out_valid_o     <= 1'b0;
            out_pc_o        <= '0;
            out_alu_res_o   <= '0;
            out_load_data_o <= '0;
            out_rd_o        <= '0;
            out_wbsel_o     <= '0;
            out_regwren_o   <= 1'b0;
            out_exc_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_pc_o        <= in_pc_i;
                        out_alu_res_o   <= in_alu_res_i;
                        out_load_data_o <= '0;
                        out_rd_o        <= in_rd_i;
                        out_wbsel_o     <= in_wbsel_i;
                        out_regwren_o   <= in_regwren_i & ~exc;
                        out_exc_o       <= exc;
                        off_q           <= off;
                        funct3_q        <= in_funct3_i;
                        is_load_q       <= in_memren_i;
                        if (mem_op && !exc) begin
                            out_valid_o  <= 1'b0;
                            dmem_req_o   <= 1'b1;
                            dmem_addr_o  <= {in_alu_res_i[AWIDTH-1:2], 2'b00};
                            dmem_we_o    <= in_memwren_i;
                            dmem_wstrb_o <= in_memwren_i ? strb_shifted : '0;
                            dmem_wdata_o <= in_memwren_i ? store_shifted : '0;
                            state        <= REQ;
                        end else begin
                            out_valid_o  <= 1'b1;
                        end
                    end else if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (is_load_q) begin
                            state <= WAIT;
                        end else begin
                            out_valid_o <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        out_load_data_o <= load_ext;
                        out_valid_o     <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_pc_i;
    logic [31:0] in_alu_res_i;
    logic [31:0] in_store_data_i;
    logic [2:0]  in_funct3_i;
    logic        in_memren_i;
    logic        in_memwren_i;
    logic [4:0]  in_rd_i;
    logic        in_regwren_i;
    logic [1:0]  in_wbsel_i;
    logic        dmem_req_o;
    logic        dmem_gnt_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_wstrb_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [31:0] out_alu_res_o;
    logic [31:0] out_load_data_o;
    logic [4:0]  out_rd_o;
    logic [1:0]  out_wbsel_o;
    logic        out_regwren_o;
    logic        out_exc_o;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
        .in_alu_res_i(in_alu_res_i), .in_store_data_i(in_store_data_i),
        .in_funct3_i(in_funct3_i), .in_memren_i(in_memren_i), .in_memwren_i(in_memwren_i),
        .in_rd_i(in_rd_i), .in_regwren_i(in_regwren_i), .in_wbsel_i(in_wbsel_i),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
        .dmem_we_o(dmem_we_o), .dmem_wstrb_o(dmem_wstrb_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
        .out_alu_res_o(out_alu_res_o), .out_load_data_o(out_load_data_o),
        .out_rd_o(out_rd_o), .out_wbsel_o(out_wbsel_o), .out_regwren_o(out_regwren_o),
        .out_exc_o(out_exc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid_i      = 1'b0;
        in_pc_i         = '0;
        in_alu_res_i    = '0;
        in_store_data_i = '0;
        in_funct3_i     = '0;
        in_memren_i     = 1'b0;
        in_memwren_i    = 1'b0;
        in_rd_i         = '0;
        in_regwren_i    = 1'b0;
        in_wbsel_i      = '0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [2:0] f3, input logic ren, input logic wen,
                           input logic [4:0] rd, input logic rwe);
        in_valid_i      = 1'b1;
        in_pc_i         = pc;
        in_alu_res_i    = alu;
        in_store_data_i = sd;
        in_funct3_i     = f3;
        in_memren_i     = ren;
        in_memwren_i    = wen;
        in_rd_i         = rd;
        in_regwren_i    = rwe;
        in_wbsel_i      = 2'b01;
    endtask

    // Responds to the request with gnt after gdly cycles and rvalid rdly cycles after gnt.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rdata, input int gdly, input int rdly,
                            input logic [31:0] exp_data, input int exp_lat);
        int   c;
        int   gcyc;
        int   lat;
        logic granted;
        logic sent;
        logic found;
        logic [31:0] data;
        logic [31:0] waddr;
        present(32'h200, addr, 32'h0, f3, 1'b1, 1'b0, 5'd7, 1'b1);
        out_ready_i   = 1'b1;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        step();
        clear_in();
        waddr = addr;
        waddr[1:0] = 2'b00;
        check({tag, " addr"}, dmem_addr_o, waddr);
        check({tag, " req/we/wstrb"}, {26'b0, dmem_req_o, dmem_we_o, dmem_wstrb_o}, 32'h20);
        granted = 1'b0; sent = 1'b0; found = 1'b0;
        gcyc = 0; lat = 0; data = '0; c = 1;
        while (!found && c <= 40) begin
            if (out_valid_o) begin
                found = 1'b1;
                lat   = c;
                data  = out_load_data_o;
            end else begin
                dmem_gnt_i    = 1'b0;
                dmem_rvalid_i = 1'b0;
                if (!granted) begin
                    if (dmem_req_o && c > gdly) begin
                        dmem_gnt_i = 1'b1;
                        granted    = 1'b1;
                        gcyc       = c;
                    end
                end else if (!sent && c > gcyc + rdly) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = rdata;
                    sent          = 1'b1;
                end
                step();
                c++;
            end
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        check({tag, " data"}, data, exp_data);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " regwren/exc"}, {30'b0, out_regwren_o, out_exc_o}, 32'h2);
        step();
        check({tag, " drained"}, {30'b0, out_valid_o, in_ready_o}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_in();
        reset         = 1'b1;
        out_ready_i   = 1'b1;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        step();
        step();
        check("reset flags", {27'b0, out_valid_o, dmem_req_o, dmem_we_o, out_regwren_o, out_exc_o}, 0);
        check("reset wstrb/addr", {28'b0, dmem_wstrb_o} | dmem_addr_o, 0);
        check("reset data", dmem_wdata_o | out_alu_res_o | out_load_data_o | out_pc_o, 0);
        reset = 1'b0;
        step();
        check("ready after reset", {31'b0, in_ready_o}, 1);

        // ADD pass-through, back-to-back
        present(32'h100, 32'h1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
        step();
        check("add valid", {31'b0, out_valid_o}, 1);
        check("add alu", out_alu_res_o, 32'h1234);
        check("add rd", {27'b0, out_rd_o}, 5);
        check("add load_data", out_load_data_o, 0);
        check("add regwren/exc/req", {29'b0, out_regwren_o, out_exc_o, dmem_req_o}, 32'h4);
        check("add ready b2b", {31'b0, in_ready_o}, 1);
        present(32'h104, 32'h5678, 32'h0, 3'b000, 1'b0, 1'b0, 5'd6, 1'b1);
        step();
        check("add2 alu", out_alu_res_o, 32'h5678);
        check("add2 pc", out_pc_o, 32'h104);
        check("add2 valid", {31'b0, out_valid_o}, 1);
        clear_in();
        step();
        check("add drained", {31'b0, out_valid_o}, 0);

        // Non-memory result stalled in IDLE blocks acceptance
        out_ready_i = 1'b0;
        present(32'h108, 32'h0000_0AAA, 32'h0, 3'b000, 1'b0, 1'b0, 5'd8, 1'b1);
        step();
        present(32'h10C, 32'h0000_0BBB, 32'h0, 3'b000, 1'b0, 1'b0, 5'd9, 1'b1);
        check("idle stall ready", {31'b0, in_ready_o}, 0);
        step();
        check("idle stall hold", out_alu_res_o, 32'h0000_0AAA);
        check("idle stall valid", {31'b0, out_valid_o}, 1);
        clear_in();
        out_ready_i = 1'b1;
        step();

        // SB at offset 3, immediate gnt
        dmem_gnt_i = 1'b1;
        present(32'h110, 32'h0100_0003, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 5'd0, 1'b0);
        step();
        clear_in();
        check("sb req/we/valid/ready", {28'b0, dmem_req_o, dmem_we_o, out_valid_o, in_ready_o}, 32'hC);
        check("sb addr", dmem_addr_o, 32'h0100_0000);
        check("sb wstrb", {28'b0, dmem_wstrb_o}, 32'h8);
        check("sb wdata", dmem_wdata_o, 32'hDD00_0000);
        step();
        dmem_gnt_i = 1'b0;
        check("sb out_valid", {31'b0, out_valid_o}, 1);
        check("sb req dropped/exc", {30'b0, dmem_req_o, out_exc_o}, 0);
        step();
        check("sb drained", {31'b0, out_valid_o}, 0);

        // SH offset 2
        dmem_gnt_i = 1'b1;
        present(32'h114, 32'h0100_0006, 32'hAABB_CCDD, 3'b001, 1'b0, 1'b1, 5'd0, 1'b0);
        step();
        clear_in();
        check("sh wstrb", {28'b0, dmem_wstrb_o}, 32'hC);
        check("sh wdata", dmem_wdata_o, 32'hCCDD_0000);
        check("sh addr", dmem_addr_o, 32'h0100_0004);
        step();
        dmem_gnt_i = 1'b0;
        step();

        // Loads: LB/LBU/LH/LHU/LW and handshake delays
        run_load("lb 80",    32'h0100_0002, 3'b000, 32'h0080_FF00, 0, 0, 32'hFFFF_FF80, 3);
        run_load("lbu 80",   32'h0100_0002, 3'b100, 32'h0080_FF00, 0, 0, 32'h0000_0080, 3);
        run_load("lb f0",    32'h0100_0002, 3'b000, 32'h00F0_0000, 0, 0, 32'hFFFF_FFF0, 3);
        run_load("lbu f0",   32'h0100_0002, 3'b100, 32'h00F0_0000, 0, 0, 32'h0000_00F0, 3);
        run_load("lh",       32'h0100_0002, 3'b001, 32'h8001_0000, 0, 0, 32'hFFFF_8001, 3);
        run_load("lhu",      32'h0100_0002, 3'b101, 32'h8001_0000, 0, 0, 32'h0000_8001, 3);
        run_load("lw",       32'h0100_0004, 3'b010, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 3);
        run_load("lb rdly3", 32'h0100_0002, 3'b000, 32'h00F0_0000, 0, 3, 32'hFFFF_FFF0, 6);
        run_load("lb gdly2", 32'h0100_0001, 3'b100, 32'h0000_5A00, 2, 0, 32'h0000_005A, 5);

        // Exceptions: misaligned LW, misaligned SH, illegal funct3, load+store
        present(32'h120, 32'h0100_0002, 32'h0, 3'b010, 1'b1, 1'b0, 5'd3, 1'b1);
        step();
        check("mis lw flags", {28'b0, out_valid_o, out_exc_o, out_regwren_o, dmem_req_o}, 32'hC);
        present(32'h124, 32'h0100_0001, 32'h0, 3'b001, 1'b0, 1'b1, 5'd0, 1'b0);
        step();
        check("mis sh flags", {29'b0, out_valid_o, out_exc_o, dmem_req_o}, 32'h6);
        present(32'h128, 32'h0100_0000, 32'h0, 3'b011, 1'b1, 1'b0, 5'd4, 1'b1);
        step();
        check("illegal f3 flags", {28'b0, out_valid_o, out_exc_o, out_regwren_o, dmem_req_o}, 32'hC);
        present(32'h12C, 32'h0100_0000, 32'h0, 3'b010, 1'b1, 1'b1, 5'd4, 1'b1);
        step();
        check("ld+st flags", {28'b0, out_valid_o, out_exc_o, out_regwren_o, dmem_req_o}, 32'hC);
        check("ld+st pc", out_pc_o, 32'h12C);
        clear_in();
        step();

        // SW with gnt withheld 4 cycles, then output stalled 3 cycles
        present(32'h130, 32'h0000_0020, 32'h1122_3344, 3'b010, 1'b0, 1'b1, 5'd0, 1'b0);
        step();
        clear_in();
        for (int i = 0; i < 4; i++) begin
            check("gnt stall req/strb", {27'b0, dmem_req_o, dmem_wstrb_o}, 32'h1F);
            check("gnt stall addr", dmem_addr_o, 32'h0000_0020);
            check("gnt stall wdata", dmem_wdata_o, 32'h1122_3344);
            step();
        end
        dmem_gnt_i  = 1'b1;
        out_ready_i = 1'b0;
        step();
        dmem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("out stall valid/ready", {30'b0, out_valid_o, in_ready_o}, 32'h2);
            check("out stall alu", out_alu_res_o, 32'h0000_0020);
            step();
        end
        out_ready_i = 1'b1;
        step();
        check("out stall released", {30'b0, out_valid_o, in_ready_o}, 32'h1);

        // Reset while in WAIT; a later rvalid must be ignored
        dmem_gnt_i = 1'b1;
        present(32'h140, 32'h0000_0040, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
        step();
        clear_in();
        step();
        dmem_gnt_i = 1'b0;
        check("wait req dropped", {31'b0, dmem_req_o}, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst mid req/valid", {30'b0, dmem_req_o, out_valid_o}, 0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFE_F00D;
        step();
        dmem_rvalid_i = 1'b0;
        check("stray rvalid valid", {31'b0, out_valid_o}, 0);
        check("stray rvalid data", out_load_data_o, 0);
        step();
        check("post reset idle", {30'b0, out_valid_o, in_ready_o}, 32'h1);

        // Reset while in REQ drops the request on the next cycle
        present(32'h144, 32'h0000_0044, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
        step();
        clear_in();
        check("req before reset", {31'b0, dmem_req_o}, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("req after reset", {31'b0, dmem_req_o}, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
